store_queue: RTL and testbench
==============================

# store_queue

Circular in-order store queue that owns every in-flight store from dispatch to memory write. It allocates entries at dispatch, captures address and data when the store executes, and marks entries committed when the ROB retires them. Committed stores drain to the data memory through a valid/ready port. It also publishes an age-ordered view of its contents (index 0 = oldest) to the load-side forwarding search, which scans from the highest index downward for the newest matching store.

## Interface
- LSQ_SIZE, 8, number of entries; power of two, ≥ 2
- IDX_W, $clog2(LSQ_SIZE), slot index width (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  dispatch requests one store entry
- alloc_ready  out  1  entry available (= !full)
- alloc_idx  out  IDX_W  physical slot granted; valid while alloc_ready
- exec_valid  in  1  store executed this cycle
- exec_idx  in  IDX_W  physical slot being filled
- exec_addr  in  32  store byte address
- exec_data  in  32  store data
- commit_valid  in  1  ROB retires the oldest uncommitted store
- flush  in  1  squash all uncommitted entries
- mem_req_valid  out  1  head store ready to write memory
- mem_req_addr  out  32  head address
- mem_req_data  out  32  head data
- mem_req_ready  in  1  memory accepts the write
- sq_valid  out  LSQ_SIZE  age-ordered forwarding-candidate valid bits
- sq_addr  out  32 × LSQ_SIZE  age-ordered addresses
- sq_data  out  32 × LSQ_SIZE  age-ordered data
- full  out  1  count == LSQ_SIZE
- empty  out  1  count == 0

## Operation
- Pointers head, cmt, and tail are each IDX_W+1 bits wide, with a wrap bit. count = tail − head (modulo 2^(IDX_W+1)). Invariant: head ≤ cmt ≤ tail in queue order.
- Per-slot state: exe bit, cmt bit, addr[31:0], data[31:0].
- Alloc: on alloc_valid && alloc_ready, slot tail[IDX_W-1:0] has exe and cmt cleared, and tail increments. alloc_idx = tail[IDX_W-1:0] combinationally.
- Exec: on exec_valid, if exec_idx is an allocated slot (between head and tail), write addr and data and set exe. Otherwise the write is ignored.
- Commit: on commit_valid, if cmt ≠ tail and the slot at cmt has exe set, set that slot's cmt bit and increment cmt. Otherwise it is a no-op.
- Drain: mem_req_valid = (head ≠ cmt). The head slot drives mem_req_addr and mem_req_data. On mem_req_valid && mem_req_ready, clear the head slot's bits and increment head.
- Flush: tail ← cmt and exe is cleared in all uncommitted slots. In the same cycle flush overrides alloc and exec. Commit and drain still proceed in that cycle, and tail takes the post-commit cmt value.
- Forwarding view: for i in 0..LSQ_SIZE−1, let p = (head + i) mod LSQ_SIZE. Then sq_valid[i] = (i < count) && exe[p], sq_addr[i] = addr[p], and sq_data[i] = data[p]. Committed-but-undrained stores remain visible.

## Timing
- Reset values: head = cmt = tail = 0; all exe and cmt bits = 0; addr and data = 0. This gives alloc_ready = 1, alloc_idx = 0, empty = 1, full = 0, mem_req_valid = 0, and sq_valid = 0.
- A mid-operation reset discards all entries immediately, including any undrained committed stores.
- All outputs are combinational from registered state. No input reaches an output combinationally.
- Visibility latency, each one cycle after the triggering edge:
  - An exec write appears on sq_* in the next cycle.
  - A commit raises mem_req_valid in the next cycle.
  - A drain handshake frees the slot in the next cycle.
- alloc_ready reflects the current count only. When the queue is full, a same-cycle drain does not enable a same-cycle alloc.
- mem_req_* are held stable while mem_req_valid && !mem_req_ready.
- Simultaneous alloc, exec, commit and drain in one cycle are all legal and independent.
- Wrap-around: the pointer wrap bit distinguishes full (index bits equal, wrap bits differ) from empty (pointers equal).

## Configuration
- SQ_FLUSH_EN
  - Defined: the flush behaviour above is compiled in.
  - Undefined: the flush input is ignored, no tail-rollback logic is generated, and tail only advances.

## Test plan
- Reset, then allocate 8 stores → alloc_idx = 0..7; full = 1 and alloc_ready = 0 after the 8th; a 9th alloc_valid is not accepted.
- Exec slot 2 with addr 0x100/data 0xAA and slot 5 with addr 0x100/data 0xBB (head = 0) → next cycle sq_valid[2] = sq_valid[5] = 1 and sq_data[5] = 0xBB; the newest match sits at the higher index.
- Exec and commit slot 0 with addr 0x40/data 0x11, mem_req_ready held 0 for 3 cycles → mem_req_valid = 1 with addr 0x40/data 0x11 stable; on ready = 1, head advances and sq_valid[0] drops next cycle.
- Wrap case: head = 6 with 4 executed entries in slots 6, 7, 0, 1 → sq_valid = 4'b1111 in bits 3..0, sq_addr[2] = slot-0 address; further allocs wrap tail correctly.
- With SQ_FLUSH_EN: 2 committed and 3 uncommitted entries, flush asserted together with alloc → next cycle count = 2, the alloc is dropped, alloc_idx = cmt index, and both committed stores still drain.
- Commit with the slot at cmt not yet executed → no-op: cmt unchanged and mem_req_valid stays 0.

Source files
------------

// File: rtl/store_queue_if.sv
// Store-queue signal bundle: dispatch, execute, commit, flush, memory-drain
// and the age-ordered forwarding view. The queue itself uses the slave modport.
interface store_queue_if #(
    parameter int LSQ_SIZE = 8
);
    localparam int IDX_W = $clog2(LSQ_SIZE);

    logic                          alloc_valid;
    logic                          alloc_ready;
    logic [IDX_W-1:0]              alloc_idx;
    logic                          exec_valid;
    logic [IDX_W-1:0]              exec_idx;
    logic [31:0]                   exec_addr;
    logic [31:0]                   exec_data;
    logic                          commit_valid;
    logic                          flush;
    logic                          mem_req_valid;
    logic [31:0]                   mem_req_addr;
    logic [31:0]                   mem_req_data;
    logic                          mem_req_ready;
    logic [LSQ_SIZE-1:0]           sq_valid;
    logic [LSQ_SIZE-1:0][31:0]     sq_addr;
    logic [LSQ_SIZE-1:0][31:0]     sq_data;
    logic                          full;
    logic                          empty;

    modport master (
        output alloc_valid, exec_valid, exec_idx, exec_addr, exec_data,
               commit_valid, flush, mem_req_ready,
        input  alloc_ready, alloc_idx, mem_req_valid, mem_req_addr, mem_req_data,
               sq_valid, sq_addr, sq_data, full, empty
    );

    modport slave (
        input  alloc_valid, exec_valid, exec_idx, exec_addr, exec_data,
               commit_valid, flush, mem_req_ready,
        output alloc_ready, alloc_idx, mem_req_valid, mem_req_addr, mem_req_data,
               sq_valid, sq_addr, sq_data, full, empty
    );
endinterface

// File: rtl/store_queue.sv
// Circular in-order store queue: alloc at tail, commit pointer in the middle, drain at head.
// Define SQ_FLUSH_EN to compile in flush (tail rollback to the commit pointer).
module store_queue #(
    parameter int LSQ_SIZE = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    store_queue_if.slave  sq
);
    localparam int IDX_W = $clog2(LSQ_SIZE);
    localparam int PW    = IDX_W + 1;

    logic [PW-1:0]    head_ptr, cmt_ptr, tail_ptr;
    logic [PW-1:0]    count;
    logic [PW-1:0]    cmt_next;
    logic [IDX_W-1:0] head_idx, cmt_idx, tail_idx;
    logic [IDX_W-1:0] exec_off;
    logic             exec_in_range;
    logic             flush_eff;
    logic             alloc_fire, exec_fire, commit_fire, drain_fire;

    logic [LSQ_SIZE-1:0] slot_exe;
    logic [LSQ_SIZE-1:0] slot_cmt;
    logic [31:0]         slot_addr [LSQ_SIZE];
    logic [31:0]         slot_data [LSQ_SIZE];

    assign head_idx = head_ptr[IDX_W-1:0];
    assign cmt_idx  = cmt_ptr[IDX_W-1:0];
    assign tail_idx = tail_ptr[IDX_W-1:0];
    assign count    = tail_ptr - head_ptr;

`ifdef SQ_FLUSH_EN
    assign flush_eff = sq.flush;
`else
    logic unused_flush;
    assign unused_flush = sq.flush;
    assign flush_eff    = 1'b0;
`endif

    assign sq.full        = (count == PW'(LSQ_SIZE));
    assign sq.empty       = (count == '0);
    assign sq.alloc_ready = !sq.full;
    assign sq.alloc_idx   = tail_idx;

    // Slot is live when its distance from head is below the occupancy.
    assign exec_off      = sq.exec_idx - head_idx;
    assign exec_in_range = ({1'b0, exec_off} < count);

    assign alloc_fire  = sq.alloc_valid && !sq.full && !flush_eff;
    assign exec_fire   = sq.exec_valid && exec_in_range && !flush_eff;
    assign commit_fire = sq.commit_valid && (cmt_ptr != tail_ptr) && slot_exe[cmt_idx];
    assign drain_fire  = sq.mem_req_valid && sq.mem_req_ready;
    assign cmt_next    = commit_fire ? cmt_ptr + PW'(1) : cmt_ptr;

    assign sq.mem_req_valid = (head_ptr != cmt_ptr);
    assign sq.mem_req_addr  = slot_addr[head_idx];
    assign sq.mem_req_data  = slot_data[head_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            cmt_ptr  <= '0;
            tail_ptr <= '0;
        end else begin
            if (alloc_fire)
                tail_ptr <= tail_ptr + PW'(1);
            if (drain_fire)
                head_ptr <= head_ptr + PW'(1);
            cmt_ptr <= cmt_next;
`ifdef SQ_FLUSH_EN
            if (flush_eff)
                tail_ptr <= cmt_next;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_exe <= '0;
            slot_cmt <= '0;
            for (int i = 0; i < LSQ_SIZE; i++) begin
                slot_addr[i] <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LSQ_SIZE; i++) begin
                if (alloc_fire && tail_idx == IDX_W'(i)) begin
                    slot_exe[i] <= 1'b0;
                    slot_cmt[i] <= 1'b0;
                end
                if (exec_fire && sq.exec_idx == IDX_W'(i)) begin
                    slot_exe[i]  <= 1'b1;
                    slot_addr[i] <= sq.exec_addr;
                    slot_data[i] <= sq.exec_data;
                end
                if (commit_fire && cmt_idx == IDX_W'(i))
                    slot_cmt[i] <= 1'b1;
`ifdef SQ_FLUSH_EN
                // The slot committing this very cycle survives the squash.
                if (flush_eff && !slot_cmt[i] && !(commit_fire && cmt_idx == IDX_W'(i)))
                    slot_exe[i] <= 1'b0;
`endif
                if (drain_fire && head_idx == IDX_W'(i)) begin
                    slot_exe[i] <= 1'b0;
                    slot_cmt[i] <= 1'b0;
                end
            end
        end
    end

    // Age-ordered view: position i maps to physical slot head+i.
    always_comb begin
        sq.sq_valid = '0;
        sq.sq_addr  = '0;
        sq.sq_data  = '0;
        for (int i = 0; i < LSQ_SIZE; i++) begin
            sq.sq_valid[i] = (PW'(i) < count) && slot_exe[head_idx + IDX_W'(i)];
            sq.sq_addr[i]  = slot_addr[head_idx + IDX_W'(i)];
            sq.sq_data[i]  = slot_data[head_idx + IDX_W'(i)];
        end
    end
endmodule

// File: tb/tb_store_queue.sv
// Randomized bench for store_queue against an age-ordered list model of in-flight stores.
// Honours SQ_FLUSH_EN the same way the design does.
module tb_store_queue;
    localparam int N = 8;
`ifdef SQ_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_queue_if #(.LSQ_SIZE(N)) ifc ();
    store_queue #(.LSQ_SIZE(N)) dut (.clk(clk), .rst_n(rst_n), .sq(ifc));

    typedef struct {
        int          idx;
        bit          exe;
        bit          cm;
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   head_phys = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int n_cmt();
        int n = 0;
        foreach (q[k]) if (q[k].cm) n++;
        return n;
    endfunction

    task automatic check_outputs();
        int sz = q.size();
        int nc = n_cmt();
        logic [N-1:0] ev = '0;
        check_val("alloc_ready", ifc.alloc_ready, sz < N);
        if (sz < N) check_val("alloc_idx", ifc.alloc_idx, (head_phys + sz) % N);
        check_val("full", ifc.full, sz == N);
        check_val("empty", ifc.empty, sz == 0);
        check_val("mem_req_valid", ifc.mem_req_valid, nc > 0);
        if (nc > 0) begin
            check_val("mem_req_addr", ifc.mem_req_addr, q[0].a);
            check_val("mem_req_data", ifc.mem_req_data, q[0].d);
        end
        for (int i = 0; i < sz; i++) ev[i] = q[i].exe;
        check_val("sq_valid", ifc.sq_valid, ev);
        for (int i = 0; i < sz; i++) begin
            if (q[i].exe) begin
                check_val("sq_addr", ifc.sq_addr[i], q[i].a);
                check_val("sq_data", ifc.sq_data[i], q[i].d);
            end
        end
    endtask

    task automatic model_update(input bit av, input bit ev, input int eidx,
                                input logic [31:0] ea, input logic [31:0] ed,
                                input bit cv, input bit fl, input bit rdy);
        int  sz = q.size();
        int  nc = n_cmt();
        bit  commit_ok = cv && (nc < sz) && q[nc].exe;
        bit  drain_ok  = (nc > 0) && rdy;
        bit  flush_eff = fl && FLUSH_ON;
        ent_t e;
        if (ev && !flush_eff) begin
            foreach (q[k]) begin
                if (q[k].idx == eidx) begin
                    q[k].exe = 1'b1;
                    q[k].a   = ea;
                    q[k].d   = ed;
                end
            end
        end
        if (commit_ok) begin
            q[nc].cm = 1'b1;
            nc++;
        end
        if (av && sz < N && !flush_eff) begin
            e.idx = (head_phys + sz) % N;
            e.exe = 1'b0;
            e.cm  = 1'b0;
            e.a   = '0;
            e.d   = '0;
            q.push_back(e);
        end
        if (flush_eff) while (q.size() > nc) void'(q.pop_back());
        if (drain_ok) begin
            void'(q.pop_front());
            head_phys = (head_phys + 1) % N;
        end
    endtask

    task automatic step(input bit av, input bit ev, input int eidx,
                        input logic [31:0] ea, input logic [31:0] ed,
                        input bit cv, input bit fl, input bit rdy);
        @(negedge clk);
        check_outputs();
        ifc.alloc_valid   = av;
        ifc.exec_valid    = ev;
        ifc.exec_idx      = eidx[2:0];
        ifc.exec_addr     = ea;
        ifc.exec_data     = ed;
        ifc.commit_valid  = cv;
        ifc.flush         = fl;
        ifc.mem_req_ready = rdy;
        model_update(av, ev, eidx, ea, ed, cv, fl, rdy);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ifc.alloc_valid = 0; ifc.exec_valid = 0; ifc.commit_valid = 0;
        ifc.flush = 0; ifc.mem_req_ready = 0;
        q.delete();
        head_phys = 0;
        @(negedge clk);
        check_val("rst_alloc_ready", ifc.alloc_ready, 1);
        check_val("rst_alloc_idx", ifc.alloc_idx, 0);
        check_val("rst_empty", ifc.empty, 1);
        check_val("rst_full", ifc.full, 0);
        check_val("rst_mem_req_valid", ifc.mem_req_valid, 0);
        check_val("rst_sq_valid", ifc.sq_valid, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int sz, eidx;
        ifc.alloc_valid = 0; ifc.exec_valid = 0; ifc.exec_idx = 0;
        ifc.exec_addr = 0; ifc.exec_data = 0; ifc.commit_valid = 0;
        ifc.flush = 0; ifc.mem_req_ready = 0;
        do_reset();

        // Fill the queue, then try a ninth alloc.
        for (int k = 0; k < N; k++) step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check_val("full_after_8", ifc.full, 1);
        check_val("no_9th_alloc", ifc.alloc_ready, 0);

        // Two stores to the same address; the younger sits at the higher index.
        step(0, 1, 2, 32'h100, 32'hAA, 0, 0, 0);
        step(0, 1, 5, 32'h100, 32'hBB, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_val("fwd_newest_data", ifc.sq_data[5], 32'hBB);
        check_val("fwd_valid_2_5", {ifc.sq_valid[5], ifc.sq_valid[2]}, 2'b11);

        // Mid-operation reset discards everything.
        do_reset();

        // Single store held by backpressure, then drained.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h40, 32'h11, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_val("held_addr", ifc.mem_req_addr, 32'h40);
        check_val("held_data", ifc.mem_req_data, 32'h11);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_val("drained_sq_valid0", ifc.sq_valid[0], 0);

        // Commit on an unexecuted slot must be a no-op.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_val("commit_noexe_noop", ifc.mem_req_valid, 0);

`ifdef SQ_FLUSH_EN
        do_reset();
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 1, k, 32'h200 + k * 4, 32'h50 + k, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_val("flush_alloc_idx", ifc.alloc_idx, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_val("flush_drained_empty", ifc.empty, 1);
`endif

        // Randomized traffic; wraps the pointers many times.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            sz = q.size();
            if (sz > 0 && ($urandom % 4) != 0) eidx = q[$urandom % sz].idx;
            else eidx = $urandom % N;
            step(($urandom % 8) < 5, ($urandom % 8) < 5, eidx, $urandom, $urandom,
                 ($urandom % 2) == 1, ($urandom % 24) == 0, ($urandom % 3) != 0);
            if (($urandom % 500) == 0) do_reset();
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
